// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU result selector.
// Decodes ALUOp/funct into a 3-bit ALU select code, selects operand B,
// supports stall (hold) and flush (bubble), flags illegal R-type functs and
// keeps a saturating count of instructions issued to EX.
module id_ex_alu_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [1:0]       id_alu_op,
  input  logic [5:0]       id_funct,
  input  logic             id_alu_src,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  output logic             ex_valid,
  output logic [2:0]       ex_alu_sel,
  output logic [WIDTH-1:0] ex_op_a,
  output logic [WIDTH-1:0] ex_op_b,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] issue_cnt
);

  // ALU select codes understood by the EX result mux
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  // R-type funct encodings
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             dec_sel_illegal_s;
  logic [2:0]       dec_sel_s;
  logic [WIDTH-1:0] dec_op_b_s;

  logic             valid_q,   valid_d;
  logic [2:0]       sel_q,     sel_d;
  logic [WIDTH-1:0] op_a_q,    op_a_d;
  logic [WIDTH-1:0] op_b_q,    op_b_d;
  logic [WIDTH-1:0] sd_q,      sd_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // Decode ALUOp/funct into the ALU select code and an illegal-funct flag
  always_comb begin
    dec_sel_s         = SEL_ADD;
    dec_sel_illegal_s = 1'b0;
    case (id_alu_op)
      2'b00: dec_sel_s = SEL_ADD;
      2'b01: dec_sel_s = SEL_SUB;
      2'b11: dec_sel_s = SEL_OR;
      2'b10: begin
        case (id_funct)
          FN_ADD:  dec_sel_s = SEL_ADD;
          FN_SUB:  dec_sel_s = SEL_SUB;
          FN_AND:  dec_sel_s = SEL_AND;
          FN_OR:   dec_sel_s = SEL_OR;
          FN_SLT:  dec_sel_s = SEL_SLT;
          default: begin
            dec_sel_s         = SEL_ADD;
            dec_sel_illegal_s = 1'b1;
          end
        endcase
      end
      default: dec_sel_s = SEL_ADD;
    endcase
  end

  // Operand B comes from the immediate for I-type, otherwise from rt
  always_comb begin
    if (id_alu_src) begin
      dec_op_b_s = id_imm;
    end else begin
      dec_op_b_s = id_rt_data;
    end
  end

  // Next-state of the pipeline register: flush beats stall beats load
  always_comb begin
    valid_d   = valid_q;
    sel_d     = sel_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sd_d      = sd_q;
    illegal_d = illegal_q;
    if (flush || (!stall && !id_valid)) begin
      // bubble: garbage decode of an invalid slot is discarded
      valid_d   = 1'b0;
      sel_d     = SEL_ADD;
      op_a_d    = '0;
      op_b_d    = '0;
      sd_d      = '0;
      illegal_d = 1'b0;
    end else if (stall) begin
      valid_d   = valid_q;
    end else begin
      valid_d   = 1'b1;
      sel_d     = dec_sel_s;
      op_a_d    = id_rs_data;
      op_b_d    = dec_op_b_s;
      sd_d      = id_rt_data;
      illegal_d = dec_sel_illegal_s;
    end
  end

  // Issue counter advances only on real loads and sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (!flush && !stall && id_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset forces bubble contents and clears the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      sel_q     <= SEL_ADD;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sd_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sd_q      <= sd_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_sel    = sel_q;
  assign ex_op_a       = op_a_q;
  assign ex_op_b       = op_b_q;
  assign ex_store_data = sd_q;
  assign ex_illegal    = illegal_q;
  assign issue_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Self-checking bench for id_ex_alu_stage: directed vector table, hand-written
// reset/stall/flush sequences and randomized traffic against a reference model.
module tb_id_ex_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;

  logic        ex_valid;
  logic [2:0]  ex_alu_sel;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic [31:0] ex_store_data;
  logic        ex_illegal;
  logic [15:0] issue_cnt;

  logic        s_valid;
  logic [2:0]  s_sel;
  logic [31:0] s_op_a;
  logic [31:0] s_op_b;
  logic [31:0] s_sd;
  logic        s_ill;
  logic [3:0]  s_cnt;

  id_ex_alu_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .ex_valid(ex_valid), .ex_alu_sel(ex_alu_sel),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
    .ex_illegal(ex_illegal), .issue_cnt(issue_cnt)
  );

  id_ex_alu_stage #(.WIDTH(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .ex_valid(s_valid), .ex_alu_sel(s_sel),
    .ex_op_a(s_op_a), .ex_op_b(s_op_b), .ex_store_data(s_sd),
    .ex_illegal(s_ill), .issue_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: what EX should hold, and how many issues happened
  logic        m_valid;
  logic [2:0]  m_sel;
  logic [31:0] m_a, m_b, m_sd;
  logic        m_ill;
  int          m_issued;

  // legal R-type functs and the select code each one means
  logic [5:0] legal_f [5];
  logic [2:0] legal_s [5];

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        src;
    logic        valid;
    logic [31:0] rs, rt, imm;
    logic        exp_valid;
    logic [2:0]  exp_sel;
    logic        exp_ill;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                            output logic [2:0] sel, output logic ill);
    sel = 3'b010;
    ill = 1'b0;
    if (op == 2'b01) sel = 3'b110;
    else if (op == 2'b11) sel = 3'b001;
    else if (op == 2'b10) begin
      ill = 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (legal_f[k] == f) begin
          sel = legal_s[k];
          ill = 1'b0;
        end
      end
    end
  endtask

  task automatic model_bubble();
    m_valid = 1'b0; m_sel = 3'b010; m_a = 32'd0; m_b = 32'd0; m_sd = 32'd0; m_ill = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int exp16, exp4;
    exp16 = (m_issued > 65535) ? 65535 : m_issued;
    exp4  = (m_issued > 15) ? 15 : m_issued;
    chk({tag, ".ex_valid"},   {63'd0, ex_valid},      {63'd0, m_valid});
    chk({tag, ".ex_alu_sel"}, {61'd0, ex_alu_sel},    {61'd0, m_sel});
    chk({tag, ".ex_op_a"},    {32'd0, ex_op_a},       {32'd0, m_a});
    chk({tag, ".ex_op_b"},    {32'd0, ex_op_b},       {32'd0, m_b});
    chk({tag, ".ex_sd"},      {32'd0, ex_store_data}, {32'd0, m_sd});
    chk({tag, ".ex_illegal"}, {63'd0, ex_illegal},    {63'd0, m_ill});
    chk({tag, ".issue_cnt"},  {48'd0, issue_cnt},     64'(exp16));
    chk({tag, ".sat_cnt"},    {60'd0, s_cnt},         64'(exp4));
    chk({tag, ".sat_sel"},    {61'd0, s_sel},         {61'd0, m_sel});
    chk({tag, ".sat_valid"},  {63'd0, s_valid},       {63'd0, m_valid});
  endtask

  // one clock edge: model follows the ID inputs present at the edge
  task automatic step(input string tag);
    logic [2:0] s;
    logic il;
    @(posedge clk);
    if (flush) model_bubble();
    else if (stall) begin end
    else if (id_valid) begin
      ref_decode(id_alu_op, id_funct, s, il);
      m_valid = 1'b1; m_sel = s; m_ill = il;
      m_a = id_rs_data; m_b = id_alu_src ? id_imm : id_rt_data; m_sd = id_rt_data;
      m_issued++;
    end else model_bubble();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic src, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm);
    id_valid = v; id_alu_op = op; id_funct = f; id_alu_src = src;
    id_rs_data = rs; id_rt_data = rt; id_imm = imm;
  endtask

  int saved_cnt;

  initial begin
    legal_f[0] = 6'b100000; legal_s[0] = 3'b010;
    legal_f[1] = 6'b100010; legal_s[1] = 3'b110;
    legal_f[2] = 6'b100100; legal_s[2] = 3'b000;
    legal_f[3] = 6'b100101; legal_s[3] = 3'b001;
    legal_f[4] = 6'b101010; legal_s[4] = 3'b111;

    //          op     funct      src  v     rs            rt            imm           ev    sel     ill   b
    vecs[0] = '{2'b10, 6'b100100, 1'b0, 1'b1, 32'h0000000F, 32'h00000003, 32'h0, 1'b1, 3'b000, 1'b0, 32'h00000003};
    vecs[1] = '{2'b10, 6'b100101, 1'b0, 1'b1, 32'h0000000F, 32'h00000003, 32'h0, 1'b1, 3'b001, 1'b0, 32'h00000003};
    vecs[2] = '{2'b10, 6'b100000, 1'b0, 1'b1, 32'h0000000F, 32'h00000003, 32'h0, 1'b1, 3'b010, 1'b0, 32'h00000003};
    vecs[3] = '{2'b10, 6'b100010, 1'b0, 1'b1, 32'h0000000F, 32'h00000003, 32'h0, 1'b1, 3'b110, 1'b0, 32'h00000003};
    vecs[4] = '{2'b10, 6'b101010, 1'b0, 1'b1, 32'h0000000F, 32'h00000003, 32'h0, 1'b1, 3'b111, 1'b0, 32'h00000003};
    vecs[5] = '{2'b00, 6'b000000, 1'b1, 1'b1, 32'h00000100, 32'h12345678, 32'hFFFFFFFC, 1'b1, 3'b010, 1'b0, 32'hFFFFFFFC};
    vecs[6] = '{2'b01, 6'b111111, 1'b0, 1'b1, 32'h00000005, 32'h00000005, 32'h0, 1'b1, 3'b110, 1'b0, 32'h00000005};
    vecs[7] = '{2'b11, 6'b000000, 1'b1, 1'b1, 32'h0000F000, 32'h00000001, 32'h000000AA, 1'b1, 3'b001, 1'b0, 32'h000000AA};
    vecs[8] = '{2'b10, 6'b000000, 1'b0, 1'b1, 32'h00000001, 32'h00000002, 32'h0, 1'b1, 3'b010, 1'b1, 32'h00000002};
    vecs[9] = '{2'b10, 6'b000000, 1'b0, 1'b0, 32'h00000001, 32'h00000002, 32'h0, 1'b0, 3'b010, 1'b0, 32'h00000000};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    model_bubble(); m_issued = 0;
    #12;
    check_all("reset_init");
    @(negedge clk); rst_n = 1'b1;

    // load one instruction, then pull reset mid-cycle
    drive(1'b1, 2'b10, 6'b100010, 1'b0, 32'hDEAD0001, 32'h00000007, 32'd0);
    step("pre_reset");
    chk("pre_reset.valid_set", {63'd0, ex_valid}, 64'd1);
    #3; rst_n = 1'b0; #1;
    model_bubble(); m_issued = 0;
    check_all("async_reset");
    @(negedge clk); rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].funct, vecs[i].src, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_valid", i), {63'd0, ex_valid},   {63'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d.tbl_sel", i),   {61'd0, ex_alu_sel}, {61'd0, vecs[i].exp_sel});
      chk($sformatf("vec%0d.tbl_ill", i),   {63'd0, ex_illegal}, {63'd0, vecs[i].exp_ill});
      chk($sformatf("vec%0d.tbl_b", i),     {32'd0, ex_op_b},    {32'd0, vecs[i].exp_b});
      if (i == 4) chk("rtype.issue5", {48'd0, issue_cnt}, 64'd5);
      if (i == 5) chk("itype.store", {32'd0, ex_store_data}, 64'h12345678);
    end

    // load SUB then stall three cycles while ID changes
    drive(1'b1, 2'b01, 6'd0, 1'b0, 32'h00000011, 32'h00000022, 32'd0);
    step("stall_load");
    saved_cnt = int'(issue_cnt);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom), 6'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
      step($sformatf("stall%0d", i));
      chk("stall.sel_frozen", {61'd0, ex_alu_sel}, 64'b110);
    end
    chk("stall.cnt_unchanged", {48'd0, issue_cnt}, 64'(saved_cnt));

    // reset while stalled, then stall + flush together
    #3; rst_n = 1'b0; #1;
    model_bubble(); m_issued = 0;
    check_all("reset_in_stall");
    @(negedge clk); rst_n = 1'b1; stall = 1'b0;
    drive(1'b1, 2'b10, 6'b000001, 1'b0, 32'h5, 32'h6, 32'd0);
    step("illegal_again");
    stall = 1'b1; flush = 1'b1;
    step("stall_flush");
    chk("stall_flush.bubble", {63'd0, ex_valid}, 64'd0);
    chk("stall_flush.cnt", {48'd0, issue_cnt}, 64'd1);
    stall = 1'b0; flush = 1'b0;

    // saturation of the narrow counter: 17 back-to-back issues
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 2'b00, 6'd0, 1'b1, $urandom, $urandom, $urandom);
      step($sformatf("sat%0d", i));
      if (i == 13) chk("sat.at15", {60'd0, s_cnt}, 64'd15);
    end
    chk("sat.hold15", {60'd0, s_cnt}, 64'd15);
    chk("sat.wide18", {48'd0, issue_cnt}, 64'd18);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive(($urandom_range(0, 3) != 0), 2'($urandom),
            ($urandom_range(0, 1) == 1) ? legal_f[$urandom_range(0, 4)] : 6'($urandom),
            1'($urandom), $urandom, $urandom, $urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
